video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
Parametrised, runtime-programmable raster timing generator and successor to the fixed 1080p H/V counter. It produces pixel/line counters plus registered hsync, vsync, data-enable, start-of-frame and end-of-line strobes. Timing comes from parameters at reset and can be reprogrammed through a register port, with changes applied only at a frame boundary. It sits at the head of the video output pipeline and feeds pattern generators and the pixel formatter.

Parameters:
HW, 12, width of horizontal counter and horizontal config fields
VW, 11, width of vertical counter and vertical config fields
H_SYNC, 44, hsync width in pixels
H_BP, 148, horizontal back porch in pixels
H_ACTIVE, 1920, active pixels per line
H_TOTAL, 2200, total pixels per line
V_SYNC, 5, vsync width in lines
V_BP, 36, vertical back porch in lines
V_ACTIVE, 1080, active lines per frame
V_TOTAL, 1125, total lines per frame
HS_POL, 1, asserted level of hsync
VS_POL, 1, asserted level of vsync

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-low reset
ce  in  1  pixel clock enable; all state advances only when ce=1
cfg_wr  in  1  write strobe for pending timing register
cfg_sel  in  3  register index: 0 h_sync, 1 h_bp, 2 h_active, 3 h_total, 4 v_sync, 5 v_bp, 6 v_active, 7 v_total
cfg_data  in  HW  write data; vertical registers use low VW bits
cfg_commit  in  1  arm pending set for application at next frame wrap
cfg_pending  out  1  commit armed, not yet applied
hcnt  out  HW  pixel position in line
vcnt  out  VW  line position in frame
hsync  out  1  horizontal sync, polarity HS_POL
vsync  out  1  vertical sync, polarity VS_POL
de  out  1  active video
sof  out  1  one-cycle strobe at hcnt=0, vcnt=0
eol  out  1  one-cycle strobe at hcnt=h_total-1

Behaviour:
- Reset is asynchronous and active-low; clock is clk. On reset: hcnt=0, vcnt=0, cfg_pending=0, and both active and pending timing sets load the parameter defaults. Outputs are hsync=HS_POL, vsync=VS_POL, de=0, sof=1 and eol=0, i.e. consistent with position (0,0).
- Line layout (active set): sync [0, h_sync-1], back porch [h_sync, h_sync+h_bp-1], active [h_sync+h_bp, h_sync+h_bp+h_active-1], front porch up to h_total-1. The vertical layout uses the same scheme with the v_* fields.
- Counting, when ce=1:
  - If hcnt=h_total-1 and vcnt=v_total-1, both counters go to 0 (frame wrap).
  - Else if hcnt=h_total-1, hcnt goes to 0 and vcnt increments.
  - Else hcnt increments.
- When ce=0, counters and all outputs hold.
- Timing of decoded outputs: hsync, vsync, de, sof and eol are registers computed from next-count values. They are valid in the same cycle as the hcnt/vcnt they describe, so there is zero latency relative to the counters.
- de = horizontal-active AND vertical-active. vsync depends only on vcnt and switches at the hcnt=0 boundary.
- Config writes: cfg_wr writes cfg_data into pending register cfg_sel. The write is unconditional and ignores ce; later writes overwrite earlier ones.
- Commit: cfg_commit sets cfg_pending.
  - At the next frame wrap (ce=1), the active set is loaded from pending and cfg_pending clears.
  - The first line of the new frame already uses the new timing.
- Simultaneous events:
  - cfg_commit in the wrap cycle: it is applied at that same wrap.
  - cfg_wr in the wrap cycle: the apply uses the pre-write pending value, and the write lands in pending.
  - cfg_commit while already pending: no effect.
- Active-set changes never occur mid-frame. Reset mid-frame abandons the frame and any pending commit.
- No legality checking is performed. Programming requires h_sync+h_bp+h_active ≤ h_total, h_total ≥ 2, and the vertical equivalents. Out-of-range programming gives undefined decode but the counters still wrap at total-1.
- Arithmetic: region boundaries are computed at HW/VW width with no overflow guard; totals up to 2^HW-1 and 2^VW-1.

Optional Feature:
FRAME_CNT_EN
- Defined: adds output frame_cnt (16 bits). It resets to 0, increments by 1 modulo 2^16 at each frame wrap with ce=1, and changes in the same cycle sof asserts.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Defaults after reset release, ce=1: hsync high for hcnt 0..43; de first high at hcnt=192, vcnt=41 and last high at hcnt=2111, vcnt=1120; vsync high for vcnt 0..4; eol at hcnt=2199; sof recurs every 2,475,000 cycles.
- ce toggling 1/0 every cycle: counts advance every other cycle; the frame period doubles to 4,950,000 cycles; outputs hold while ce=0.
- Program a small raster (3,2,8,16 / 1,1,4,8) plus commit mid-frame: cfg_pending=1 until the 1080p wrap, then the next frame has a line period of 16 and a frame period of 128; de high for hcnt 5..12, vcnt 2..5.
- cfg_commit and cfg_wr(sel 3, data 20) in the wrap cycle: the new frame uses h_total 16; a second commit applies 20 at the following wrap.
- Assert reset mid-line with cfg_pending=1: all outputs immediately return to reset values, defaults are restored and cfg_pending=0.
- With FRAME_CNT_EN and the small raster: frame_cnt increments on each sof and wraps 65535→0.

Source files
------------

// File: rtl/video_timing_gen_if.sv
// Configuration and raster-timing bundle between the timing generator (slave)
// and whoever programs it and consumes its timing (master).
interface video_timing_gen_if #(
    parameter int HW = 12,
    parameter int VW = 11
);
    logic          ce;
    logic          cfg_wr;
    logic [2:0]    cfg_sel;
    logic [HW-1:0] cfg_data;
    logic          cfg_commit;
    logic          cfg_pending;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic          sof;
    logic          eol;

    modport master (
        output ce, cfg_wr, cfg_sel, cfg_data, cfg_commit,
        input  cfg_pending, hcnt, vcnt, hsync, vsync, de, sof, eol
    );

    modport slave (
        input  ce, cfg_wr, cfg_sel, cfg_data, cfg_commit,
        output cfg_pending, hcnt, vcnt, hsync, vsync, de, sof, eol
    );
endinterface

// File: rtl/video_timing_gen.sv
// Runtime-programmable raster timing generator; new timing is applied only at frame wrap.
// Optional FRAME_CNT_EN adds a 16-bit frame counter output.
module video_timing_gen #(
    parameter int HW       = 12,
    parameter int VW       = 11,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int H_ACTIVE = 1920,
    parameter int H_TOTAL  = 2200,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter int V_ACTIVE = 1080,
    parameter int V_TOTAL  = 1125,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1
) (
    input  logic              clk,
    input  logic              reset,
`ifdef FRAME_CNT_EN
    output logic [15:0]       frame_cnt,
`endif
    video_timing_gen_if.slave vif
);
    localparam logic HS_L = (HS_POL != 0);
    localparam logic VS_L = (VS_POL != 0);

    // Index 0..3 = sync, back porch, active, total (same order for H and V).
    function automatic logic [HW-1:0] h_default(input int idx);
        case (idx)
            0:       return HW'(H_SYNC);
            1:       return HW'(H_BP);
            2:       return HW'(H_ACTIVE);
            default: return HW'(H_TOTAL);
        endcase
    endfunction

    function automatic logic [VW-1:0] v_default(input int idx);
        case (idx)
            0:       return VW'(V_SYNC);
            1:       return VW'(V_BP);
            2:       return VW'(V_ACTIVE);
            default: return VW'(V_TOTAL);
        endcase
    endfunction

    logic [HW-1:0] h_pend_reg [4];
    logic [VW-1:0] v_pend_reg [4];
    logic [HW-1:0] h_act_reg  [4];
    logic [VW-1:0] v_act_reg  [4];
    logic [HW-1:0] h_act_next [4];
    logic [VW-1:0] v_act_next [4];

    logic          cfg_pending_reg;
    logic [HW-1:0] hcnt_reg, hcnt_next;
    logic [VW-1:0] vcnt_reg, vcnt_next;
    logic          hsync_reg, vsync_reg, de_reg, sof_reg, eol_reg;
    logic          hsync_next, vsync_next, de_next, sof_next, eol_next;
    logic          at_eol, at_eof, wrap, apply;
    logic [HW-1:0] h_act_start, h_act_end;
    logic [VW-1:0] v_act_start, v_act_end;

    assign at_eol = (hcnt_reg == h_act_reg[3] - 1'b1);
    assign at_eof = at_eol && (vcnt_reg == v_act_reg[3] - 1'b1);
    assign wrap   = vif.ce && at_eof;
    // A commit arriving in the wrap cycle itself takes effect at that wrap.
    assign apply  = wrap && (cfg_pending_reg || vif.cfg_commit);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cfg
            // Pending writes ignore ce; apply reads the pre-write value.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    h_pend_reg[gi] <= h_default(gi);
                    v_pend_reg[gi] <= v_default(gi);
                end else if (vif.cfg_wr) begin
                    if (vif.cfg_sel == 3'(gi))
                        h_pend_reg[gi] <= vif.cfg_data;
                    if (vif.cfg_sel == 3'(gi + 4))
                        v_pend_reg[gi] <= vif.cfg_data[VW-1:0];
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    h_act_reg[gi] <= h_default(gi);
                    v_act_reg[gi] <= v_default(gi);
                end else if (apply) begin
                    h_act_reg[gi] <= h_pend_reg[gi];
                    v_act_reg[gi] <= v_pend_reg[gi];
                end
            end

            assign h_act_next[gi] = apply ? h_pend_reg[gi] : h_act_reg[gi];
            assign v_act_next[gi] = apply ? v_pend_reg[gi] : v_act_reg[gi];
        end
    endgenerate

    always_comb begin
        hcnt_next = hcnt_reg + 1'b1;
        vcnt_next = vcnt_reg;
        if (at_eol) begin
            hcnt_next = '0;
            vcnt_next = at_eof ? '0 : vcnt_reg + 1'b1;
        end
    end

    // Decode from next counts and next timing set so outputs line up with the counters.
    always_comb begin
        h_act_start = h_act_next[0] + h_act_next[1];
        h_act_end   = h_act_start + h_act_next[2];
        v_act_start = v_act_next[0] + v_act_next[1];
        v_act_end   = v_act_start + v_act_next[2];
        hsync_next  = (hcnt_next < h_act_next[0]) ? HS_L : ~HS_L;
        vsync_next  = (vcnt_next < v_act_next[0]) ? VS_L : ~VS_L;
        de_next     = (hcnt_next >= h_act_start) && (hcnt_next < h_act_end) &&
                      (vcnt_next >= v_act_start) && (vcnt_next < v_act_end);
        sof_next    = (hcnt_next == '0) && (vcnt_next == '0);
        eol_next    = (hcnt_next == h_act_next[3] - 1'b1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcnt_reg  <= '0;
            vcnt_reg  <= '0;
            hsync_reg <= HS_L;
            vsync_reg <= VS_L;
            de_reg    <= 1'b0;
            sof_reg   <= 1'b1;
            eol_reg   <= 1'b0;
        end else if (vif.ce) begin
            hcnt_reg  <= hcnt_next;
            vcnt_reg  <= vcnt_next;
            hsync_reg <= hsync_next;
            vsync_reg <= vsync_next;
            de_reg    <= de_next;
            sof_reg   <= sof_next;
            eol_reg   <= eol_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cfg_pending_reg <= 1'b0;
        else if (apply)
            cfg_pending_reg <= 1'b0;
        else if (vif.cfg_commit)
            cfg_pending_reg <= 1'b1;
    end

`ifdef FRAME_CNT_EN
    logic [15:0] frame_cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            frame_cnt_reg <= '0;
        else if (wrap)
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end

    assign frame_cnt = frame_cnt_reg;
`endif

    assign vif.cfg_pending = cfg_pending_reg;
    assign vif.hcnt        = hcnt_reg;
    assign vif.vcnt        = vcnt_reg;
    assign vif.hsync       = hsync_reg;
    assign vif.vsync       = vsync_reg;
    assign vif.de          = de_reg;
    assign vif.sof         = sof_reg;
    assign vif.eol         = eol_reg;
endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench: a frame-position model (linear pixel index per frame) predicts every output each cycle.
module tb_video_timing_gen;
    localparam int HW = 12, VW = 11;
    localparam int P_HS = 4, P_HBP = 6, P_HA = 20, P_HT = 40;
    localparam int P_VS = 2, P_VBP = 3, P_VA = 10, P_VT = 20;
    localparam int HS_POL = 1, VS_POL = 0;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    video_timing_gen_if #(.HW(HW), .VW(VW)) vif();
`ifdef FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    video_timing_gen #(
        .HW(HW), .VW(VW),
        .H_SYNC(P_HS), .H_BP(P_HBP), .H_ACTIVE(P_HA), .H_TOTAL(P_HT),
        .V_SYNC(P_VS), .V_BP(P_VBP), .V_ACTIVE(P_VA), .V_TOTAL(P_VT),
        .HS_POL(HS_POL), .VS_POL(VS_POL)
    ) dut (
        .clk(clk),
        .reset(reset),
`ifdef FRAME_CNT_EN
        .frame_cnt(frame_cnt),
`endif
        .vif(vif)
    );

    int n_assert = 0;
    int n_fail = 0;

    // Model: position is a single pixel index within the frame; sets are plain int arrays.
    int m_p, m_fc;
    int m_act[8];
    int m_pend[8];
    bit m_pending;

    function automatic void model_reset();
        m_p = 0;
        m_fc = 0;
        m_pending = 0;
        m_act = '{P_HS, P_HBP, P_HA, P_HT, P_VS, P_VBP, P_VA, P_VT};
        m_pend = m_act;
    endfunction

    function automatic bit model_at_wrap();
        return m_p == m_act[3] * m_act[7] - 1;
    endfunction

    function automatic void model_step(bit ce_v, bit wr_v, int sel_v, int data_v, bit commit_v);
        if (ce_v && model_at_wrap()) begin
            m_p = 0;
            m_fc = (m_fc + 1) % 65536;
            if (m_pending || commit_v) begin
                m_act = m_pend;
                m_pending = 0;
            end
        end else begin
            if (ce_v) m_p++;
            if (commit_v) m_pending = 1;
        end
        if (wr_v) m_pend[sel_v] = (sel_v >= 4) ? (data_v % (1 << VW)) : data_v;
    endfunction

    task automatic finish_test();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int ht, x, y, h0, v0;
        ht = m_act[3];
        x = m_p % ht;
        y = m_p / ht;
        h0 = m_act[0] + m_act[1];
        v0 = m_act[4] + m_act[5];
        check("hcnt", vif.hcnt, x);
        check("vcnt", vif.vcnt, y);
        check("hsync", vif.hsync, (x < m_act[0]) ? HS_POL : 1 - HS_POL);
        check("vsync", vif.vsync, (y < m_act[4]) ? VS_POL : 1 - VS_POL);
        check("de", vif.de, (x >= h0 && x < h0 + m_act[2] && y >= v0 && y < v0 + m_act[6]) ? 1 : 0);
        check("sof", vif.sof, (m_p == 0) ? 1 : 0);
        check("eol", vif.eol, (x == ht - 1) ? 1 : 0);
        check("cfg_pending", vif.cfg_pending, m_pending);
`ifdef FRAME_CNT_EN
        check("frame_cnt", frame_cnt, m_fc);
`endif
    endtask

    task automatic cycle(input bit ce_v, input bit wr_v, input int sel_v, input int data_v, input bit commit_v);
        vif.ce = ce_v;
        vif.cfg_wr = wr_v;
        vif.cfg_sel = 3'(sel_v);
        vif.cfg_data = 12'(data_v);
        vif.cfg_commit = commit_v;
        @(posedge clk);
        model_step(ce_v, wr_v, sel_v, data_v, commit_v);
        #1;
        check_outputs();
        if (n_fail > 40) finish_test();
    endtask

    task automatic run_until_applied(input bit rand_ce);
        int budget;
        budget = 4000;
        while (m_pending && budget > 0) begin
            cycle(rand_ce ? 1'($urandom_range(0, 1)) : 1'b1, 0, 0, 0, 0);
            budget--;
        end
        check("apply_within_budget", (budget > 0) ? 1 : 0, 1);
    endtask

    task automatic program_set(input int cfg[8], input bit rand_ce);
        for (int i = 0; i < 8; i++)
            cycle(rand_ce ? 1'($urandom_range(0, 1)) : 1'b1, 1, i, cfg[i], 0);
        cycle(1, 0, 0, 0, 1);
    endtask

    initial begin
        int small_set[8];
        int rs[8];
        int budget;

        vif.ce = 0; vif.cfg_wr = 0; vif.cfg_sel = 0; vif.cfg_data = 0; vif.cfg_commit = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        reset = 1'b1;

        // Default raster, free running: one full frame plus a bit.
        repeat (850) cycle(1, 0, 0, 0, 0);

        // ce toggling every cycle: counters and outputs must hold on the idle cycles.
        for (int i = 0; i < 1700; i++) cycle(i % 2 == 0, 0, 0, 0, 0);

        // Small raster programmed mid-frame; applied only at the next wrap.
        small_set = '{3, 2, 8, 16, 1, 1, 4, 8};
        program_set(small_set, 0);
        run_until_applied(0);
        repeat (300) cycle(1, 0, 0, 0, 0);

        // Commit plus write of h_total in the wrap cycle: apply sees the old pending value.
        budget = 500;
        while (!model_at_wrap() && budget > 0) begin
            cycle(1, 0, 0, 0, 0);
            budget--;
        end
        check("reach_wrap", (budget > 0) ? 1 : 0, 1);
        cycle(1, 1, 3, 20, 1);
        repeat (40) cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1);
        run_until_applied(0);
        repeat (200) cycle(1, 0, 0, 0, 0);

        // Random legal rasters with random ce and stray writes.
        for (int k = 0; k < 6; k++) begin
            rs[0] = $urandom_range(1, 4);
            rs[1] = $urandom_range(0, 3);
            rs[2] = $urandom_range(1, 10);
            rs[3] = rs[0] + rs[1] + rs[2] + $urandom_range(0, 5);
            rs[4] = $urandom_range(1, 2);
            rs[5] = $urandom_range(0, 2);
            rs[6] = $urandom_range(1, 4);
            rs[7] = rs[4] + rs[5] + rs[6] + $urandom_range(0, 2);
            program_set(rs, 1);
            run_until_applied(1);
            repeat (300) cycle(1'($urandom_range(0, 1)), 0, 0, 0, 0);
        end

        // Asynchronous reset mid-line with a commit pending.
        program_set(small_set, 0);
        repeat (7) cycle(1, 0, 0, 0, 0);
        check("pending_before_reset", vif.cfg_pending, 1);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        reset = 1'b1;
        repeat (900) cycle(1, 0, 0, 0, 0);

        finish_test();
    end
endmodule
